// File: rtl/vega_fetch_unit.sv
// -----------------------------------------------------------------------------
// vega_fetch_unit
//
// Purpose:
//   Instruction fetch front end with a private program memory. The memory is
//   written through the load port while the unit is idle or halted. When
//   started, the unit streams instructions to a decode stage, one per cycle
//   sustained. It follows branch redirects and stops when the halt opcode is
//   accepted.
//
// Ports:
//   clk            in   single clock, rising edge
//   reset          in   asynchronous, active-high reset
//   start          in   level; begins fetch from IDLE or HALT
//   load_en        in   program-memory write strobe (honoured in IDLE/HALT only)
//   load_addr      in   [PC_WIDTH]    program-memory write address
//   load_data      in   [INSTR_WIDTH] program-memory write data
//   branch_valid   in   redirect request (honoured in FETCH only)
//   branch_target  in   [PC_WIDTH]    redirect address
//   out_ready      in   decode stage accepts out_instr
//   out_valid      out  out_instr/out_pc hold a valid instruction
//   out_instr      out  [INSTR_WIDTH] fetched instruction
//   out_pc         out  [PC_WIDTH]    address of out_instr
//   halted         out  high while in HALT
//   retired_count  out  [16] accepted instructions, saturating
//   state_dbg      out  [2]  current FSM state (0 IDLE, 1 FETCH, 2 HALT)
//
// Handshake (valid/ready):
//   A transfer happens on every rising edge where out_valid=1 and
//   out_ready=1. Once out_valid is raised, out_valid, out_instr and out_pc do
//   not change until that transfer, a branch flush, or reset. out_valid never
//   depends combinationally on out_ready.
// -----------------------------------------------------------------------------
module vega_fetch_unit #(
  parameter int unsigned              PC_WIDTH    = 8,
  parameter int unsigned              INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]      RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0]   HALT_OPCODE = '1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   load_en,
  input  logic [PC_WIDTH-1:0]    load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   branch_valid,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic                   halted,
  output logic [15:0]            retired_count,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam int unsigned DEPTH = 1 << PC_WIDTH;

  state_t                 state_q;
  logic [PC_WIDTH-1:0]    pc_q;
  logic                   out_valid_q;
  logic [INSTR_WIDTH-1:0] out_instr_q;
  logic [PC_WIDTH-1:0]    out_pc_q;
  logic                   halted_q;
  logic [15:0]            retired_q;

  // Program memory. It has no reset so that its contents survive a reset.
  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

  logic                   transfer;
  logic                   halt_accept;
  logic [PC_WIDTH-1:0]    pc_inc_d;
  logic [15:0]            retired_inc_d;
  logic [INSTR_WIDTH-1:0] fetch_word;

  assign transfer      = out_valid_q & out_ready;
  assign halt_accept   = transfer & (out_instr_q == HALT_OPCODE);
  // The natural modulo-2**PC_WIDTH add gives the required wrap to 0.
  assign pc_inc_d      = pc_q + PC_WIDTH'(1);
  assign retired_inc_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
  assign fetch_word    = mem_q[pc_q];

  // Loads are only allowed while the fetch stream is stopped. Ignoring them
  // in FETCH keeps instructions already in flight consistent with memory.
  always_ff @(posedge clk) begin
    if (load_en && (state_q != FETCH)) begin
      mem_q[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      halted_q    <= 1'b0;
      retired_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
          end
        end

        FETCH: begin
          // An accepted instruction is always counted, including one that
          // leaves together with a branch flush or the halt opcode itself.
          if (transfer) begin
            retired_q <= retired_inc_d;
          end

          if (halt_accept) begin
            // Halt wins over a coincident branch. The branch is dropped.
            state_q     <= HALT;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b1;
          end else if (branch_valid) begin
            // Flush the output slot. The target word is fetched on the next
            // edge because out_valid will be low then.
            pc_q        <= branch_target;
            out_valid_q <= 1'b0;
          end else if (!out_valid_q || transfer) begin
            out_instr_q <= fetch_word;
            out_pc_q    <= pc_q;
            out_valid_q <= 1'b1;
            pc_q        <= pc_inc_d;
          end
        end

        HALT: begin
          if (start) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            retired_q <= '0;
            halted_q  <= 1'b0;
          end
        end

        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          halted_q    <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid     = out_valid_q;
  assign out_instr     = out_instr_q;
  assign out_pc        = out_pc_q;
  assign halted        = halted_q;
  assign retired_count = retired_q;
  assign state_dbg     = state_q;

endmodule

// File: doc/vega_fetch_unit.md
VEGA_FETCH_UNIT -- requirements
Module: vega_fetch_unit

Interface
REQ-001 Parameter PC_WIDTH, 8: program counter width; instruction memory depth SHALL be 2**PC_WIDTH.
REQ-002 Parameter INSTR_WIDTH, 16: instruction word width.
REQ-003 Parameter RESET_PC, 0: fetch start address.
REQ-004 Parameter HALT_OPCODE, all ones (INSTR_WIDTH bits): instruction word that stops fetch.
REQ-005 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port start, input, 1: level; begins fetch from IDLE or HALT.
REQ-008 Port load_en, input, 1: program-memory write strobe.
REQ-009 Port load_addr, input, PC_WIDTH: program-memory write address.
REQ-010 Port load_data, input, INSTR_WIDTH: program-memory write data.
REQ-011 Port branch_valid, input, 1: redirect request.
REQ-012 Port branch_target, input, PC_WIDTH: redirect address.
REQ-013 Port out_ready, input, 1: downstream decode accepts out_instr.
REQ-014 Port out_valid, output, 1: out_instr/out_pc hold a valid instruction.
REQ-015 Port out_instr, output, INSTR_WIDTH: fetched instruction.
REQ-016 Port out_pc, output, PC_WIDTH: address of out_instr.
REQ-017 Port halted, output, 1: high while in HALT.
REQ-018 Port retired_count, output, 16: count of accepted instructions.

Function
REQ-019 States SHALL be IDLE, FETCH, HALT; IDLE->FETCH when start=1; FETCH->HALT on acceptance of HALT_OPCODE; HALT->FETCH when start=1, with pc=RESET_PC and retired_count cleared.
REQ-020 Handshake: a transfer occurs in any cycle with out_valid=1 and out_ready=1.
REQ-021 While out_valid=1 and out_ready=0, out_instr, out_pc and out_valid SHALL remain stable.
REQ-022 In FETCH with out_valid=0 or a transfer, the next edge SHALL load out_instr=mem[pc], out_pc=pc, out_valid=1, pc=pc+1 (1-cycle latency, one instruction per cycle sustained).
REQ-023 pc SHALL wrap from 2**PC_WIDTH-1 to 0 without error.
REQ-024 branch_valid=1 in FETCH SHALL set pc=branch_target and out_valid=0 at the next edge; the target instruction SHALL appear valid one cycle after that.
REQ-025 Branch coincident with a transfer: the transfer SHALL count, then the flush SHALL apply.
REQ-026 Acceptance of HALT_OPCODE SHALL take priority over a coincident branch; the branch SHALL be dropped.
REQ-027 On entering HALT out_valid SHALL be 0 and halted SHALL be 1; branch_valid SHALL be ignored in IDLE and HALT.
REQ-028 load_en SHALL write mem[load_addr]=load_data only in IDLE or HALT; writes in FETCH SHALL be ignored.
REQ-029 retired_count SHALL increment by 1 per transfer and saturate at 16'hFFFF.

Reset
REQ-030 reset=1 SHALL immediately force state=IDLE, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0, retired_count=0, regardless of clk.
REQ-031 Reset mid-FETCH SHALL abandon any held instruction; memory contents SHALL be preserved.
REQ-032 After reset release, no fetch SHALL occur until start=1.

Verification
REQ-033 Load mem[0..3]=1,2,3,HALT_OPCODE; start; out_ready=1 -> out_instr 1,2,3,HALT on consecutive cycles, out_pc 0..3, then halted=1, retired_count=4.
REQ-034 Same program, out_ready=0 for 3 cycles after first valid -> out_instr=1, out_pc=0 held 4 cycles, no instruction lost or duplicated.
REQ-035 Branch to address 8 (mem[8]=0x0A0A) while out_pc=1 and out_ready=1 -> instruction 2 counted, out_valid=0 one cycle, then out_instr=0x0A0A, out_pc=8.
REQ-036 PC_WIDTH=2, no halt in memory, out_ready=1 -> out_pc sequence 0,1,2,3,0,1.
REQ-037 Assert reset between clock edges during FETCH -> outputs at reset values before the next edge; load_en during FETCH leaves memory unchanged.
REQ-038 Halt with count 4, then start -> fetch resumes at RESET_PC, retired_count=0, halted=0.
